// File: rtl/sr_reg_bank.sv
// sr_reg_bank: per-channel set/clear/data flops with sticky latching and post-set hold stretching.
// Define SR_BANK_EVENT_EN to add rising-edge event flags (o_evt, i_ack) and a registered o_irq.
module sr_reg_bank #(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned HOLD     = 0,
  parameter int unsigned SET_WINS = 0
) (
  input  logic            i_clk,
  input  logic            i_arst_n,
  input  logic [N_CH-1:0] i_clr,
  input  logic [N_CH-1:0] i_set,
  input  logic [N_CH-1:0] i_dat,
  input  logic [N_CH-1:0] i_sticky,
`ifdef SR_BANK_EVENT_EN
  input  logic [N_CH-1:0] i_ack,
  output logic [N_CH-1:0] o_evt,
  output logic            o_irq,
`endif
  output logic [N_CH-1:0] o_dat
);

  localparam int unsigned   CW     = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_V = CW'(HOLD);

  logic [N_CH-1:0] clr_eff;
  logic [N_CH-1:0] q_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];

  // With set-wins, a coincident set masks the clear so the set row takes over.
  always_comb begin
    clr_eff = i_clr;
    if (SET_WINS != 0) begin
      clr_eff = i_clr & ~i_set;
    end
  end

  // Per-channel next state: clear, set, sticky, hold countdown, then data.
  always_comb begin
    q_d = o_dat;
    for (int c = 0; c < int'(N_CH); c++) begin
      cnt_d[c] = cnt_q[c];
      if (clr_eff[c]) begin
        q_d[c]   = 1'b0;
        cnt_d[c] = '0;
      end else if (i_set[c]) begin
        q_d[c]   = 1'b1;
        cnt_d[c] = HOLD_V;
      end else if (o_dat[c] && i_sticky[c]) begin
        q_d[c]   = 1'b1;
      end else if (cnt_q[c] != '0) begin
        q_d[c]   = 1'b1;
        cnt_d[c] = cnt_q[c] - CW'(1);
      end else begin
        q_d[c]   = i_dat[c];
        cnt_d[c] = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_dat <= '0;
      for (int c = 0; c < int'(N_CH); c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      o_dat <= q_d;
      for (int c = 0; c < int'(N_CH); c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

`ifdef SR_BANK_EVENT_EN
  // A new rise outranks a simultaneous acknowledge; irq trails the flags by one cycle.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_evt <= '0;
      o_irq <= 1'b0;
    end else begin
      o_evt <= (o_evt & ~i_ack) | (q_d & ~o_dat);
      o_irq <= |o_evt;
    end
  end
`endif

endmodule
